uart_rx_voter: RTL and testbench
================================

Name: uart_rx_voter

Overview:
- Serial UART receiver at the far end of the error-injecting `channel` block: `uart_tx -> channel -> uart_rx_voter`.
- Recovers 8N1/8E1/8O1 frames from the possibly corrupted line using a 3-sample majority vote per bit.
- Reports parity and framing errors per frame.
- Keeps a saturating count of bad frames so the channel's error rate can be measured in simulation and on hardware.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit period; legal minimum 4.
- PARITY_EN, 1, 1 = frame carries one parity bit after the data bits; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
- CNT_W, 16, width of the bad-frame counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial line from the channel; idle high; asynchronous to clk.
- err_clr  in  1  synchronous clear of err_count.
- data  out  8  last received byte, LSB first on the line.
- valid  out  1  one-cycle pulse; data and the error flags are updated on that cycle.
- parity_err  out  1  parity mismatch for the frame marked by valid.
- frame_err  out  1  stop bit voted 0 for the frame marked by valid.
- busy  out  1  high whenever the FSM is not IDLE.
- err_count  out  CNT_W  saturating count of frames with parity_err or frame_err.

Behaviour:
- Reset:
  - data = 0, valid = 0, parity_err = 0, frame_err = 0, busy = 0, err_count = 0.
  - FSM goes to IDLE.
  - Both synchroniser flops and the edge-detect register reset to 1 (line idle).
- Input path: rx passes through a 2-flop synchroniser to give rx_s; rx_s_d is rx_s delayed by one cycle.
- Bit timing:
  - A bit counter runs 0..CLKS_PER_BIT-1; MID = CLKS_PER_BIT/2 (integer division).
  - rx_s is sampled at counter = MID-1, MID and MID+1.
  - vote = majority of the 3 samples, available at counter = MID+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - rx_s_d = 1 and rx_s = 0 (falling edge) -> go to START with counter = 0.
  - No other event leaves IDLE.
- START:
  - At MID+1, vote = 1 -> false start: return to IDLE. No valid, no flags, err_count unchanged.
  - At counter = CLKS_PER_BIT-1, go to DATA with bit index = 0 and counter = 0.
- DATA:
  - Vote at MID+1 is shifted into the shift register, LSB first.
  - After bit index 7 completes its period: go to PARITY if PARITY_EN, else STOP.
- PARITY:
  - Store the vote.
  - Expected value = XOR of the 8 data bits, XOR PARITY_ODD.
  - At the end of the period, go to STOP.
- STOP:
  - At MID+1, evaluate the vote and return to IDLE on the next edge. The remaining half bit is not waited out, so a back-to-back start edge is caught.
  - On the cycle after the stop vote:
    - valid = 1 for exactly one cycle.
    - data = shift register.
    - frame_err = ~stop_vote.
    - parity_err = PARITY_EN & (parity_vote != expected).
  - valid pulses on every completed frame, errored or not. The flags hold their value until the next valid.
- busy = (state != IDLE).
- err_count:
  - Increments by 1 on a valid cycle with parity_err | frame_err.
  - Saturates at all-ones.
  - err_clr = 1 sets it to 0 on the next edge; err_clr wins over a simultaneous increment.
- Latency: the end of the stop bit's MID+1 sample on rx is 2 sync cycles + 1 register cycle before valid.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values. The partial frame is discarded with no valid.
- A line held low (break) produces one frame: data = 0x00 and frame_err = 1. The FSM then waits in IDLE for a new falling edge; a constant 0 never retriggers.
- Single-sample corruption (one of the three votes) never changes a recovered bit.

Test Plan:
All scenarios use CLKS_PER_BIT = 16, PARITY_EN = 1, PARITY_ODD = 0.
- Clean frame, byte 0xA5 with even parity bit 0 and stop bit 1 -> single valid pulse, data = 0xA5, parity_err = 0, frame_err = 0, err_count = 0.
- 0x3C with rx inverted for 1 clk at the MID sample of data bits 2 and 5 -> data = 0x3C, no errors. Repeat with 3 clks inverted spanning MID-1..MID+1 of bit 2 -> data = 0x38, parity_err = 1, err_count = 1.
- 3-clk low glitch on idle line -> no valid, busy drops within 1 bit period. A following clean frame 0x01 is received correctly.
- 0x7E with stop bit forced 0 -> frame_err = 1, err_count increments. 0x7E with parity bit flipped -> parity_err = 1, frame_err = 0.
- Two frames back-to-back with no idle gap (0x55 then 0xAA) -> two valid pulses, data = 0x55 then 0xAA, no errors.
- Assert rst during data bit 4 -> busy = 0 and no valid. err_count saturation: preload via 2^CNT_W errored frames (use CNT_W = 3) -> count holds at 7. err_clr asserted on the same cycle as an errored valid -> err_count = 0.

Source files
------------

// File: rtl/uart_rx_voter.sv
// UART receiver with 3-sample majority voting per bit.
// Reports parity/framing errors and keeps a saturating bad-frame count.
module uart_rx_voter #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic             err_clr,
    output logic [7:0]       data,
    output logic             valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy,
    output logic [CNT_W-1:0] err_count
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int MID = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] C_S0  = CW'(MID - 1);
    localparam logic [CW-1:0] C_S1  = CW'(MID);
    localparam logic [CW-1:0] C_V   = CW'(MID + 1);
    localparam logic [CW-1:0] C_END = CW'(CLKS_PER_BIT - 1);

    localparam logic P_EN  = (PARITY_EN != 0);
    localparam logic P_ODD = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic          rx_m;
    logic          rx_s;
    logic          rx_s_d;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          smp0;
    logic          smp1;
    logic [7:0]    shreg;
    logic          par_v;

    logic vote;
    logic at_vote;
    logic at_end;
    logic exp_par;

    assign vote    = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
    assign at_vote = (cnt == C_V);
    assign at_end  = (cnt == C_END);
    assign exp_par = (^shreg) ^ P_ODD;
    assign busy    = (state != S_IDLE);

    // Sync flops reset high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            rx_m   <= rx;
            rx_s   <= rx_m;
            rx_s_d <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            smp0       <= 1'b1;
            smp1       <= 1'b1;
            shreg      <= '0;
            par_v      <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (cnt == C_S0) smp0 <= rx_s;
            if (cnt == C_S1) smp1 <= rx_s;
            case (state)
                S_IDLE: begin
                    if (rx_s_d && !rx_s) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (at_vote && vote) begin
                        state <= S_IDLE;
                    end else if (at_end) begin
                        state   <= S_DATA;
                        cnt     <= '0;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (at_vote) shreg <= {vote, shreg[7:1]};
                    if (at_end) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= P_EN ? S_PAR : S_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_PAR: begin
                    if (at_vote) par_v <= vote;
                    if (at_end) begin
                        cnt   <= '0;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    // Leave at the stop vote so a back-to-back start is seen.
                    if (at_vote) begin
                        state      <= S_IDLE;
                        valid      <= 1'b1;
                        data       <= shreg;
                        frame_err  <= ~vote;
                        parity_err <= P_EN & (par_v != exp_par);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (valid && (parity_err || frame_err) && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_rx_voter.sv
// Bench for uart_rx_voter: fixed vectors, corner sequences and a
// randomized line checked against a sample-level frame model.
module tb_uart_rx_voter;

    localparam int CPB = 16;
    localparam int MID = CPB / 2;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          err_clr = 1'b0;
    logic [7:0]    data;
    logic          valid;
    logic          parity_err;
    logic          frame_err;
    logic          busy;
    logic [CW-1:0] err_count;

    uart_rx_voter #(
        .CLKS_PER_BIT(CPB),
        .PARITY_EN(1),
        .PARITY_ODD(0),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .err_clr(err_clr),
        .data(data),
        .valid(valid),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .busy(busy),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pflip;
        logic       stopv;
        int         g0;
        int         l0;
        int         g1;
        int         l1;
        logic [7:0] ed;
        logic       epe;
        logic       efe;
    } vec_t;

    int         n_vec = 0;
    int         n_bad = 0;
    int         model_cnt = 0;
    logic       line_q[$];
    logic [9:0] rcv_q[$];
    logic [9:0] exp_q[$];
    logic       clr_on_valid = 1'b0;
    logic       dbl = 1'b0;
    logic       prev_v = 1'b0;
    logic       busy_seen = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    function automatic logic lv(input int i);
        return (i < 0 || i >= line_q.size()) ? 1'b1 : line_q[i];
    endfunction

    // Majority of the three line samples around the middle of a bit.
    function automatic logic vote_at(input int b);
        int ones;
        ones = int'(lv(b + MID)) + int'(lv(b + MID + 1)) + int'(lv(b + MID + 2));
        return ones >= 2;
    endfunction

    task automatic sat_inc();
        if (model_cnt < (1 << CW) - 1) model_cnt++;
    endtask

    task automatic push_n(input logic v, input int n);
        for (int i = 0; i < n; i++) line_q.push_back(v);
    endtask

    task automatic push_frame(input logic [7:0] d, input logic pflip,
                              input logic stopv, output int base);
        logic [10:0] f;
        f = {stopv, (^d) ^ pflip, d, 1'b0};
        base = line_q.size();
        for (int k = 0; k < 11; k++) push_n(f[k], CPB);
    endtask

    task automatic glitch(input int base, input int fbit, input int len);
        int off;
        int idx;
        off = (len == 1) ? MID + 1 : MID;
        for (int j = 0; j < len; j++) begin
            idx = base + fbit * CPB + off + j;
            line_q[idx] = ~line_q[idx];
        end
    endtask

    task automatic play(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(posedge clk);
            #1 rx = line_q[i];
        end
    endtask

    task automatic begin_scn();
        line_q.delete();
        rcv_q.delete();
        dbl = 1'b0;
        busy_seen = 1'b0;
    endtask

    // Walk the whole line waveform: find falling edges, vote each bit.
    task automatic run_model();
        int         p;
        logic [10:0] v;
        logic [7:0] d;
        logic       pe;
        logic       fe;
        exp_q.delete();
        p = 0;
        while (p < line_q.size()) begin
            if (lv(p - 1) && !lv(p)) begin
                if (vote_at(p)) begin
                    p = p + MID + 3;
                end else begin
                    v = '0;
                    for (int k = 1; k < 11; k++) v[k] = vote_at(p + k * CPB);
                    d  = v[8:1];
                    pe = (v[9] != ^d);
                    fe = !v[10];
                    exp_q.push_back({d, pe, fe});
                    if (pe || fe) sat_inc();
                    p = p + 10 * CPB + MID + 3;
                end
            end else begin
                p++;
            end
        end
    endtask

    task automatic finish_scn(input string nm);
        int n;
        run_model();
        chk({nm, "_nframes"}, rcv_q.size(), exp_q.size());
        n = (rcv_q.size() < exp_q.size()) ? rcv_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_frame%0d", nm, i), rcv_q[i], exp_q[i]);
        chk({nm, "_errcnt"}, err_count, model_cnt);
        chk({nm, "_pulse"}, dbl, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (valid) rcv_q.push_back({data, parity_err, frame_err});
            if (valid && prev_v) dbl = 1'b1;
            prev_v = valid;
            if (busy) busy_seen = 1'b1;
            err_clr = valid && clr_on_valid;
            if (valid) clr_on_valid = 1'b0;
        end
    end

    initial begin
        vec_t tbl[8];
        int   b;
        int   b2;
        int   gap;

        tbl[0] = '{8'hA5, 1'b0, 1'b1, -1, 0, -1, 0, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 1'b1,  3, 1,  6, 1, 8'h3C, 1'b0, 1'b0};
        tbl[2] = '{8'h3C, 1'b0, 1'b1,  3, 3, -1, 0, 8'h38, 1'b1, 1'b0};
        tbl[3] = '{8'h7E, 1'b0, 1'b0, -1, 0, -1, 0, 8'h7E, 1'b0, 1'b1};
        tbl[4] = '{8'h7E, 1'b1, 1'b1, -1, 0, -1, 0, 8'h7E, 1'b1, 1'b0};
        tbl[5] = '{8'h01, 1'b0, 1'b1, -1, 0, -1, 0, 8'h01, 1'b0, 1'b0};
        tbl[6] = '{8'h55, 1'b0, 1'b1, -1, 0, -1, 0, 8'h55, 1'b0, 1'b0};
        tbl[7] = '{8'hAA, 1'b0, 1'b1, -1, 0, -1, 0, 8'hAA, 1'b0, 1'b0};

        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errcnt", err_count, 0);

        for (int t = 0; t < 8; t++) begin
            begin_scn();
            push_n(1'b1, 20);
            push_frame(tbl[t].d, tbl[t].pflip, tbl[t].stopv, b);
            if (tbl[t].g0 >= 0) glitch(b, tbl[t].g0, tbl[t].l0);
            if (tbl[t].g1 >= 0) glitch(b, tbl[t].g1, tbl[t].l1);
            push_n(1'b1, 200);
            play(0, line_q.size());
            if (tbl[t].epe || tbl[t].efe) sat_inc();
            chk($sformatf("vec%0d_nvalid", t), rcv_q.size(), 1);
            if (rcv_q.size() == 1) begin
                chk($sformatf("vec%0d_data", t), rcv_q[0][9:2], tbl[t].ed);
                chk($sformatf("vec%0d_perr", t), rcv_q[0][1], tbl[t].epe);
                chk($sformatf("vec%0d_ferr", t), rcv_q[0][0], tbl[t].efe);
            end
            chk($sformatf("vec%0d_errcnt", t), err_count, model_cnt);
        end

        begin_scn();
        push_n(1'b1, 20);
        push_n(1'b0, 3);
        push_n(1'b1, CPB);
        play(0, line_q.size());
        @(negedge clk);
        chk("glitch_busy_seen", busy_seen, 1);
        chk("glitch_busy_low", busy, 0);
        chk("glitch_nvalid", rcv_q.size(), 0);
        begin_scn();
        push_n(1'b1, 10);
        push_frame(8'h01, 1'b0, 1'b1, b);
        push_n(1'b1, 200);
        play(0, line_q.size());
        finish_scn("after_glitch");

        begin_scn();
        push_n(1'b1, 20);
        push_frame(8'h55, 1'b0, 1'b1, b);
        push_frame(8'hAA, 1'b0, 1'b1, b2);
        push_n(1'b1, 200);
        play(0, line_q.size());
        finish_scn("b2b");
        if (rcv_q.size() == 2) begin
            chk("b2b_first", rcv_q[0], {8'h55, 2'b00});
            chk("b2b_second", rcv_q[1], {8'hAA, 2'b00});
        end

        begin_scn();
        push_n(1'b1, 20);
        push_n(1'b0, 300);
        push_n(1'b1, 200);
        play(0, line_q.size());
        finish_scn("break");
        if (rcv_q.size() == 1) chk("break_frame", rcv_q[0], {8'h00, 2'b01});

        begin_scn();
        push_n(1'b1, 20);
        for (int f = 0; f < 20; f++) begin
            push_frame(8'($urandom_range(0, 255)),
                       ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 9) != 0), b);
            gap = $urandom_range(0, 40);
            push_n(1'b1, gap);
        end
        for (int i = 20; i < line_q.size(); i++)
            if ($urandom_range(0, 199) == 0) line_q[i] = ~line_q[i];
        push_n(1'b1, 200);
        play(0, line_q.size());
        finish_scn("random");

        chk("pre_rst_errcnt_nonzero", (err_count != 0), 1);
        begin_scn();
        push_n(1'b1, 20);
        push_frame(8'h96, 1'b0, 1'b1, b);
        play(0, b + 5 * CPB + MID);
        @(posedge clk);
        #1 rst = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_data", data, 0);
        chk("midrst_errcnt", err_count, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_cnt = 0;
        repeat (250) @(posedge clk);
        @(negedge clk);
        chk("midrst_nvalid", rcv_q.size(), 0);
        chk("midrst_idle", busy, 0);

        begin_scn();
        for (int f = 0; f < 9; f++) begin
            push_n(1'b1, 20);
            push_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, b);
        end
        push_n(1'b1, 200);
        play(0, line_q.size());
        finish_scn("sat");
        chk("sat_hold7", err_count, 7);

        begin_scn();
        clr_on_valid = 1'b1;
        push_n(1'b1, 20);
        push_frame(8'h7E, 1'b0, 1'b0, b);
        push_n(1'b1, 200);
        play(0, line_q.size());
        chk("clr_nvalid", rcv_q.size(), 1);
        chk("clr_errcnt", err_count, 0);
        model_cnt = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
